fma_vector_checker: RTL

//  Self-checking vector sequencer for the FMA datapath, parametrised in format width and pipeline depth.

---
 rtl/fma_vector_checker.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/fma_vector_checker.sv
// Vector sequencer and result checker for FMA datapaths.
// Streams ROM vectors into the DUT and scores results after LATENCY.
module fma_vector_checker #(
  parameter int WIDTH   = 16,
  parameter int FLAGW   = 4,
  parameter int CTRLW   = 8,
  parameter int AW      = 15,
  parameter int LATENCY = 0,
  parameter int ERRW    = 32,
  localparam int VW     = 4*WIDTH+CTRLW+FLAGW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [AW:0]      num_vectors,
  input  logic [FLAGW-1:0] flag_mask,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [VW-1:0]    mem_data,
  output logic [WIDTH-1:0] dut_x,
  output logic [WIDTH-1:0] dut_y,
  output logic [WIDTH-1:0] dut_z,
  output logic [1:0]       dut_roundmode,
  output logic             dut_mul,
  output logic             dut_add,
  output logic             dut_negp,
  output logic             dut_negz,
  input  logic [WIDTH-1:0] dut_result,
  input  logic [FLAGW-1:0] dut_flags,
  output logic             busy,
  output logic             done,
  output logic [ERRW-1:0]  vec_count,
  output logic [ERRW-1:0]  err_count,
  output logic             err_valid,
  output logic [AW-1:0]    err_index,
  output logic [WIDTH-1:0] err_result,
  output logic [WIDTH-1:0] err_expected,
  output logic [AW-1:0]    first_err
);

  localparam int RO = FLAGW;
  localparam int CO = FLAGW+WIDTH;
  localparam int ZO = CO+CTRLW;
  localparam int YO = ZO+WIDTH;
  localparam int XO = YO+WIDTH;
  localparam int DW = $clog2(LATENCY+2);

  typedef enum logic [1:0] {
    IDLE, FETCH, DRAIN, DONE
  } state_t;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] r;
    logic [FLAGW-1:0] f;
    logic [AW-1:0]    i;
  } exp_t;

  state_t           state;
  logic [AW:0]      nv_q;
  logic [DW-1:0]    dcnt;
  logic             fed;
  logic [AW-1:0]    fed_idx;
  logic [WIDTH-1:0] hx, hy, hz;
  logic [5:0]       hc, vc;
  logic             have_err;
  logic             go;
  logic             mism;
  exp_t             st0, cmp;
  logic             unused_ctrl;

  assign unused_ctrl = &{1'b0, mem_data[CO+6 +: CTRLW-6]};

  assign go   = start && (state == IDLE || state == DONE);
  assign busy = (state == FETCH) || (state == DRAIN);
  assign done = (state == DONE);

  // ROM data is live on the cycle after the read; hold it afterwards
  assign dut_x = fed ? mem_data[XO +: WIDTH] : hx;
  assign dut_y = fed ? mem_data[YO +: WIDTH] : hy;
  assign dut_z = fed ? mem_data[ZO +: WIDTH] : hz;
  assign vc    = fed ? mem_data[CO +: 6] : hc;

  assign dut_roundmode = vc[5:4];
  assign dut_mul       = vc[3];
  assign dut_add       = vc[2];
  assign dut_negp      = vc[1];
  assign dut_negz      = vc[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      nv_q      <= '0;
      dcnt      <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      fed       <= 1'b0;
      fed_idx   <= '0;
      hx        <= '0;
      hy        <= '0;
      hz        <= '0;
      hc        <= '0;
    end else begin
      fed     <= mem_rd_en;
      fed_idx <= mem_addr;
      if (fed) begin
        hx <= mem_data[XO +: WIDTH];
        hy <= mem_data[YO +: WIDTH];
        hz <= mem_data[ZO +: WIDTH];
        hc <= mem_data[CO +: 6];
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            nv_q     <= num_vectors;
            mem_addr <= '0;
            hx       <= '0;
            hy       <= '0;
            hz       <= '0;
            hc       <= '0;
            if (num_vectors == '0) begin
              state <= DONE;
            end else begin
              state     <= FETCH;
              mem_rd_en <= 1'b1;
            end
          end
        end
        FETCH: begin
          if ({1'b0, mem_addr} == nv_q - 1'b1) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
            dcnt      <= '0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == DW'(LATENCY)) begin
            state <= DONE;
            hx    <= '0;
            hy    <= '0;
            hz    <= '0;
            hc    <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign st0 = '{v: fed,
                 r: mem_data[RO +: WIDTH],
                 f: mem_data[FLAGW-1:0],
                 i: fed_idx};

  if (LATENCY == 0) begin : g_comb
    assign cmp = st0;
  end else begin : g_pipe
    exp_t pipe [LATENCY];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < LATENCY; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= st0;
        for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign cmp = pipe[LATENCY-1];
  end

  // X/Z on the result must register as a mismatch
  always_comb begin
    mism = 1'b0;
    if (cmp.v)
      mism = (dut_result !== cmp.r) ||
             (|((dut_flags ^ cmp.f) & flag_mask));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_count    <= '0;
      err_count    <= '0;
      err_valid    <= 1'b0;
      err_index    <= '0;
      err_result   <= '0;
      err_expected <= '0;
      first_err    <= '0;
      have_err     <= 1'b0;
    end else if (go) begin
      vec_count <= '0;
      err_count <= '0;
      err_valid <= 1'b0;
      first_err <= '0;
      have_err  <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      if (cmp.v) begin
        vec_count <= vec_count + 1'b1;
        if (mism) begin
          if (err_count != '1) err_count <= err_count + 1'b1;
          err_valid    <= 1'b1;
          err_index    <= cmp.i;
          err_result   <= dut_result;
          err_expected <= cmp.r;
          if (!have_err) first_err <= cmp.i;
          have_err <= 1'b1;
        end
      end
    end
  end

endmodule
